// File: rtl/cipher_pkg.sv
// Shared definitions for the block-cipher datapath: beat modes and Rijndael
// row-rotation geometry for state widths of 4, 6 or 8 columns.
package cipher_pkg;

  typedef enum logic [1:0] {
    MODE_FWD = 2'b00,
    MODE_INV = 2'b01,
    MODE_BYP = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  localparam int unsigned ROWS = 4;

  // Rijndael rotates rows 2 and 3 one step further once the block reaches 8 columns.
  function automatic int unsigned row_offset(input int unsigned nb, input int unsigned row);
    if (nb == 8 && row >= 2) return row + 1;
    return row;
  endfunction

  // LSB position of state byte (row, col); byte 0 sits at the MSB, column-major.
  function automatic int unsigned byte_lsb(input int unsigned nb, input int unsigned row,
                                           input int unsigned col);
    return 32 * nb - 8 - 8 * (ROWS * col + row);
  endfunction

  function automatic int unsigned fwd_src_col(input int unsigned nb, input int unsigned row,
                                              input int unsigned col);
    return (col + row_offset(nb, row)) % nb;
  endfunction

  function automatic int unsigned inv_src_col(input int unsigned nb, input int unsigned row,
                                              input int unsigned col);
    return (col + nb - row_offset(nb, row)) % nb;
  endfunction

endpackage

// File: rtl/rijndael_row_perm.sv
// Combinational ShiftRows / InvShiftRows / bypass for an NB-column Rijndael state.
module rijndael_row_perm
  import cipher_pkg::*;
#(
  parameter int unsigned NB = 4
) (
  input  logic [32*NB-1:0] data_i,
  input  mode_e            mode_i,
  output logic [32*NB-1:0] data_o
);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("rijndael_row_perm: NB must be 4, 6 or 8");
  end

  logic [32*NB-1:0] fwd_w;
  logic [32*NB-1:0] inv_w;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int unsigned DST  = byte_lsb(NB, r, c);
      localparam int unsigned FSRC = byte_lsb(NB, r, fwd_src_col(NB, r, c));
      localparam int unsigned ISRC = byte_lsb(NB, r, inv_src_col(NB, r, c));
      assign fwd_w[DST +: 8] = data_i[FSRC +: 8];
      assign inv_w[DST +: 8] = data_i[ISRC +: 8];
    end
  end

  // Reserved encoding falls through to bypass.
  always_comb begin
    data_o = data_i;
    case (mode_i)
      MODE_FWD: data_o = fwd_w;
      MODE_INV: data_o = inv_w;
      default:  data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_rows_stream.sv
// Pipelined row-permutation stage: permutes on the input side, then holds beats in
// a main register plus one skid entry so in_ready is purely registered.
module shift_rows_stream
  import cipher_pkg::*;
#(
  parameter int unsigned NB    = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [32*NB-1:0]   in_data,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [32*NB-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned DW = 32 * NB;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [DW-1:0]    data;
  } beat_t;

  logic [DW-1:0] perm_w;
  beat_t         in_beat;
  beat_t         main_q, main_d;
  beat_t         skid_q, skid_d;
  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          accept;
  logic          drain;

  rijndael_row_perm #(
    .NB(NB)
  ) u_perm (
    .data_i(in_data),
    .mode_i(mode_e'(in_mode)),
    .data_o(perm_w)
  );

  assign in_beat  = '{tag: in_tag, data: perm_w};
  assign in_ready = !skid_valid_q && !rst;
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid_q && out_ready;

  // Skid is only ever full while main is full, so main-empty implies skid-empty.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;

    if (drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end

    if (accept) begin
      if (!main_valid_q || (drain && !skid_valid_q)) begin
        main_d       = in_beat;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_beat;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_q.data;
  assign out_tag   = main_q.tag;

endmodule
